spram_bank_ctrl: RTL and testbench

- Parametrised controller over an array of iCE40 SB_SPRAM256KA tiles (16K x 16 each), arranged as BANKS deep by LANES wide.
- Presents a valid/ready request port with byte write masks and a 1-cycle read response.
- Adds idle-driven sleep/wake power management that a single SPRAM wrapper cannot provide.
- Sits between the SoC bus bridge and the physical SPRAMs.

---
 rtl/spram_pkg.sv | 25 ++
 rtl/spram_tile.sv | 58 +++++
 rtl/spram_bank_ctrl.sv | 149 ++++++++++++++
 tb/tb_spram_bank_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spram_pkg
// Purpose  : Shared constants, state encoding and mask helper for the SPRAM
//            bank controller.
// Revision : 1.0
// ============================================================================
package spram_pkg;

    localparam int SPRAM_ADDR_W = 14;
    localparam int SPRAM_DW     = 16;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        SLEEP  = 2'd1,
        WAKE   = 2'd2
    } state_e;

    // Two byte enables of one 16-bit lane become the tile's four nibble enables.
    function automatic logic [3:0] byte_to_nibble_mask(input logic [1:0] byte_mask);
        return {{2{byte_mask[1]}}, {2{byte_mask[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spram_tile.sv
`default_nettype none
// ============================================================================
// Module   : spram_tile
// Purpose  : One 16K x 16 iCE40 SPRAM tile; behavioural stand-in outside synthesis.
// Revision : 1.0
// ============================================================================
module spram_tile (
    input  logic        clock,
    input  logic [13:0] address,
    input  logic [15:0] datain,
    input  logic [3:0]  maskwren,
    input  logic        wren,
    input  logic        chipselect,
    input  logic        standby,
    input  logic        sleep,
    input  logic        poweroff,
    output logic [15:0] dataout
);

`ifdef SYNTHESIS
    SB_SPRAM256KA u_spram (
        .ADDRESS    (address),
        .DATAIN     (datain),
        .MASKWREN   (maskwren),
        .WREN       (wren),
        .CHIPSELECT (chipselect),
        .CLOCK      (clock),
        .STANDBY    (standby),
        .SLEEP      (sleep),
        .POWEROFF   (poweroff),
        .DATAOUT    (dataout)
    );
`else
    logic [15:0] r_mem [0:16383];
    logic [15:0] r_dout;
    logic        w_access;

    assign w_access = chipselect && !standby && !sleep && poweroff;

    // Output register only loads on reads, so it holds while deselected.
    always_ff @(posedge clock) begin
        if (w_access && wren) begin
            for (int n = 0; n < 4; n++) begin
                if (maskwren[n]) begin
                    r_mem[address][4*n +: 4] <= datain[4*n +: 4];
                end
            end
        end
        if (w_access && !wren) begin
            r_dout <= r_mem[address];
        end
    end

    assign dataout = r_dout;
`endif

endmodule
`default_nettype wire

// File: rtl/spram_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spram_bank_ctrl
// Purpose  : Valid/ready front end over a BANKS x LANES SPRAM array with
//            idle-driven sleep and timed wake.
// Revision : 1.0
// ============================================================================
module spram_bank_ctrl
    import spram_pkg::*;
#(
    parameter  int BANKS             = 4,
    parameter  int LANES             = 2,
    parameter  int IDLE_SLEEP_CYCLES = 64,
    parameter  int WAKE_CYCLES       = 4,
    localparam int DW                = SPRAM_DW * LANES,
    localparam int AW                = SPRAM_ADDR_W + $clog2(BANKS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [AW-1:0]    req_addr,
    input  logic [2*LANES-1:0] req_wmask,
    input  logic [DW-1:0]    req_wdata,
    output logic             resp_valid,
    output logic [DW-1:0]    resp_data,
    input  logic             sleep_en,
    output logic             sleeping
);

    localparam int c_BW     = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int c_IDLE_W = (IDLE_SLEEP_CYCLES > 1) ? $clog2(IDLE_SLEEP_CYCLES) : 1;
    localparam int c_WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic c_SLEEP_ON = (IDLE_SLEEP_CYCLES != 0);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST =
        c_IDLE_W'((IDLE_SLEEP_CYCLES > 0) ? IDLE_SLEEP_CYCLES - 1 : 0);
    localparam logic [c_WAKE_W-1:0] c_WAKE_LAST =
        c_WAKE_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [c_IDLE_W-1:0]   r_idle_cnt;
    logic [c_IDLE_W-1:0]   w_idle_cnt_nxt;
    logic [c_WAKE_W-1:0]   r_wake_cnt;
    logic [c_WAKE_W-1:0]   w_wake_cnt_nxt;
    logic                  w_accept;
    logic                  w_idle_cycle;
    logic                  w_sleep_pin;
    logic [c_BW-1:0]       w_sel_bank;
    logic [BANKS-1:0]      w_cs;
    logic [DW-1:0]         w_bank_dout [BANKS];

    assign w_accept     = req_valid && req_ready;
    assign w_idle_cycle = (r_state == ACTIVE) && !w_accept && sleep_en && c_SLEEP_ON;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ACTIVE;
            r_idle_cnt <= '0;
            r_wake_cnt <= '0;
            resp_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
            r_wake_cnt <= w_wake_cnt_nxt;
            resp_valid <= w_accept && !req_write;
        end
    end

    // Counters default to zero so every state exit leaves them cleared.
    always_comb begin
        w_state_nxt    = r_state;
        w_idle_cnt_nxt = '0;
        w_wake_cnt_nxt = '0;
        case (r_state)
            ACTIVE: begin
                if (w_idle_cycle) begin
                    if (r_idle_cnt == c_IDLE_LAST) begin
                        w_state_nxt = SLEEP;
                    end else begin
                        w_idle_cnt_nxt = r_idle_cnt + 1'b1;
                    end
                end
            end
            SLEEP: begin
                if (req_valid || !sleep_en) begin
                    w_state_nxt = WAKE;
                end
            end
            WAKE: begin
                if (r_wake_cnt == c_WAKE_LAST) begin
                    w_state_nxt = ACTIVE;
                end else begin
                    w_wake_cnt_nxt = r_wake_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ACTIVE;
        endcase
    end

    always_comb begin
        req_ready   = (r_state == ACTIVE) && !reset;
        sleeping    = (r_state == SLEEP);
        w_sleep_pin = (r_state == SLEEP);
    end

    generate
        if (BANKS > 1) begin : g_multi_bank
            logic [c_BW-1:0] r_bank;

            assign w_sel_bank = req_addr[SPRAM_ADDR_W +: c_BW];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_bank <= '0;
                end else if (w_accept && !req_write) begin
                    r_bank <= w_sel_bank;
                end
            end

            assign resp_data = w_bank_dout[r_bank];
        end else begin : g_single_bank
            assign w_sel_bank = '0;
            assign resp_data  = w_bank_dout[0];
        end

        for (genvar b = 0; b < BANKS; b++) begin : g_bank
            assign w_cs[b] = w_accept && (w_sel_bank == c_BW'(b));

            for (genvar l = 0; l < LANES; l++) begin : g_lane
                spram_tile u_tile (
                    .clock      (clock),
                    .address    (req_addr[SPRAM_ADDR_W-1:0]),
                    .datain     (req_wdata[SPRAM_DW*l +: SPRAM_DW]),
                    .maskwren   (byte_to_nibble_mask(req_wmask[2*l +: 2])),
                    .wren       (w_cs[b] && req_write),
                    .chipselect (w_cs[b]),
                    .standby    (1'b0),
                    .sleep      (w_sleep_pin),
                    .poweroff   (1'b1),
                    .dataout    (w_bank_dout[b][SPRAM_DW*l +: SPRAM_DW])
                );
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_spram_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spram_bank_ctrl
// Purpose  : Directed self-checking bench for spram_bank_ctrl (4 banks x 2 lanes).
// Revision : 1.0
// ============================================================================
module tb_spram_bank_ctrl;

    localparam int BANKS = 4;
    localparam int LANES = 2;
    localparam int DW    = 32;
    localparam int AW    = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_wmask;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic          sleep_en;
    logic          sleeping;

    int checks = 0;
    int errors = 0;

    spram_bank_ctrl #(
        .BANKS             (BANKS),
        .LANES             (LANES),
        .IDLE_SLEEP_CYCLES (64),
        .WAKE_CYCLES       (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wmask  (req_wmask),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .sleep_en   (sleep_en),
        .sleeping   (sleeping)
    );

    always #5 clock = ~clock;

    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
        @(negedge clock);
        req_valid = 1'b0; req_write = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, output logic v, output logic [31:0] d);
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a;
        @(negedge clock);
        req_valid = 1'b0;
        v = resp_valid;
        d = resp_data;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #12;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", req_ready); end
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        checks++;
        if (sleeping !== 1'b0) begin errors++; $display("FAIL reset_sleeping got %b exp 0", sleeping); end
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_banks;
        logic        v;
        logic [31:0] d;
        do_write(16'h4000, 32'h0000_0000, 4'hF);
        do_write(16'h8000, 32'h0000_0000, 4'hF);
        do_write(16'hC000, 32'h0000_0000, 4'hF);
        do_write(16'h0000, 32'hDEAD_BEEF, 4'hF);
        do_write(16'h4001, 32'hDEAD_BEEF, 4'hF);
        do_write(16'h8002, 32'hDEAD_BEEF, 4'hF);
        do_write(16'hC003, 32'hDEAD_BEEF, 4'hF);
        for (int i = 0; i < 4; i++) begin
            do_read(16'(i * 16'h4000 + i), v, d);
            checks++;
            if (v !== 1'b1 || d !== 32'hDEAD_BEEF) begin
                errors++; $display("FAIL bank%0d_read got v=%b d=%h exp v=1 d=deadbeef", i, v, d);
            end
        end
        for (int i = 1; i < 4; i++) begin
            do_read(16'(i * 16'h4000), v, d);
            checks++;
            if (v !== 1'b1 || d !== 32'h0000_0000) begin
                errors++; $display("FAIL bank%0d_other got v=%b d=%h exp v=1 d=00000000", i, v, d);
            end
        end
    endtask

    task automatic test_mask;
        logic        v;
        logic [31:0] d;
        do_write(16'h0010, 32'hFFFF_FFFF, 4'hF);
        do_write(16'h0010, 32'h1234_5678, 4'b0101);
        do_read(16'h0010, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'hFF34_FF78) begin
            errors++; $display("FAIL mask_write got v=%b d=%h exp v=1 d=ff34ff78", v, d);
        end
        do_write(16'h0010, 32'h0000_0000, 4'b0000);
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL mask0_no_resp got %b exp 0", resp_valid); end
        do_read(16'h0010, v, d);
        checks++;
        if (d !== 32'hFF34_FF78) begin errors++; $display("FAIL mask0_unchanged got %h exp ff34ff78", d); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            do_write(16'(16'h0100 + i), 32'h1000_0100 + 32'(i), 4'hF);
        end
        @(negedge clock);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                req_valid = 1'b1; req_write = 1'b0; req_addr = 16'(16'h0100 + i);
                checks++;
                if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, req_ready); end
            end else begin
                req_valid = 1'b0;
            end
            if (i > 0) begin
                checks++;
                if (resp_valid !== 1'b1 || resp_data !== 32'h1000_0100 + 32'(i - 1)) begin
                    errors++;
                    $display("FAIL b2b_resp[%0d] got v=%b d=%h exp v=1 d=%h", i - 1, resp_valid, resp_data,
                             32'h1000_0100 + 32'(i - 1));
                end
            end
            @(negedge clock);
        end
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra_resp got %b exp 0", resp_valid); end
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0200; req_wdata = 32'h5A5A_1234; req_wmask = 4'hF;
        @(negedge clock);
        req_write = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h5A5A_1234) begin
            errors++; $display("FAIL raw_forward got v=%b d=%h exp v=1 d=5a5a1234", resp_valid, resp_data);
        end
    endtask

    task automatic test_sleep;
        int n;
        int lat;
        @(negedge clock);
        sleep_en = 1'b1;
        repeat (60) @(negedge clock);
        checks++;
        if (sleeping !== 1'b0) begin errors++; $display("FAIL sleep_early got %b exp 0", sleeping); end
        n = 0;
        while (sleeping !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        checks++;
        if (60 + n !== 64) begin errors++; $display("FAIL sleep_idle_cycles got %0d exp 64", 60 + n); end
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL sleep_ready got %b exp 0", req_ready); end
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010;
        lat = 0;
        while (req_ready !== 1'b1 && lat < 10) begin @(negedge clock); lat++; end
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL wake_latency got %0d exp 5", lat); end
        @(negedge clock);
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'hFF34_FF78) begin
            errors++; $display("FAIL wake_read got v=%b d=%h exp v=1 d=ff34ff78", resp_valid, resp_data);
        end
        sleep_en = 1'b0;
    endtask

    task automatic test_sleep_disable;
        int cnt;
        int n;
        sleep_en = 1'b0;
        cnt = 0;
        repeat (1000) begin @(negedge clock); if (sleeping !== 1'b0) cnt++; end
        checks++;
        if (cnt !== 0) begin errors++; $display("FAIL sleep_disabled got %0d sleeping cycles exp 0", cnt); end
        sleep_en = 1'b1;
        n = 0;
        while (sleeping !== 1'b1 && n < 100) begin @(negedge clock); n++; end
        checks++;
        if (sleeping !== 1'b1) begin errors++; $display("FAIL sleep_reenter got %b exp 1", sleeping); end
        sleep_en = 1'b0;
        @(negedge clock);
        checks++;
        if (sleeping !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL wake_state got sleeping=%b ready=%b exp 0 0", sleeping, req_ready);
        end
        n = 1;
        while (req_ready !== 1'b1 && n < 10) begin @(negedge clock); n++; end
        checks++;
        if (n !== 5) begin errors++; $display("FAIL sleep_en_wake_latency got %0d exp 5", n); end
    endtask

    task automatic test_reset_mid;
        int          n;
        logic        v;
        logic [31:0] d;
        do_write(16'h0020, 32'hCAFE_F00D, 4'hF);
        sleep_en = 1'b1;
        n = 0;
        while (sleeping !== 1'b1 && n < 100) begin @(negedge clock); n++; end
        sleep_en = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0 || sleeping !== 1'b0) begin
            errors++; $display("FAIL reset_in_wake got ready=%b sleeping=%b exp 0 0", req_ready, sleeping);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL active_after_reset got %b exp 1", req_ready); end
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0020;
        @(posedge clock);
        #2;
        reset = 1'b1;
        req_valid = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_read got %b exp 0", resp_valid); end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_after_reset got %b exp 0", resp_valid); end
        do_read(16'h0020, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL readback_0020 got v=%b d=%h exp v=1 d=cafef00d", v, d);
        end
        do_read(16'hC003, v, d);
        checks++;
        if (v !== 1'b1 || d !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL readback_c003 got v=%b d=%h exp v=1 d=deadbeef", v, d);
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wmask = '0;
        req_wdata = '0;
        sleep_en  = 1'b0;
        test_reset();
        test_banks();
        test_mask();
        test_back_to_back();
        test_sleep();
        test_sleep_disable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
